// File: rtl/cajero_pkg.sv
// Shared definitions for the cajero_param ATM transaction controller.
//   state_t       : controller states
//   TIPO_DEPOSITO : TIPO_TRANS value selecting a deposit
//   TIPO_RETIRO   : TIPO_TRANS value selecting a withdrawal
package cajero_pkg;

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_PIN_ENTRY    = 3'd1,
    S_CHECK_PIN    = 3'd2,
    S_ESPERA_MONTO = 3'd3,
    S_DEPOSITO     = 3'd4,
    S_RETIRO       = 3'd5,
    S_BLOQUEO      = 3'd6
  } state_t;

  localparam logic TIPO_DEPOSITO = 1'b0;
  localparam logic TIPO_RETIRO   = 1'b1;

  // True in the states where the inactivity timer runs.
  function automatic logic timed_state(input state_t s);
    return (s == S_PIN_ENTRY) || (s == S_ESPERA_MONTO);
  endfunction

endpackage

// File: rtl/stb_edge.sv
// Rising-edge detector for a level strobe.
//   i_clk    : clock
//   i_rst    : synchronous active-high reset
//   i_in     : level input
//   o_rise_c : high in the cycle where i_in is 1 and its registered copy is 0
module stb_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_in,
  output logic o_rise_c
);

  logic r_prev;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_prev <= 1'b0;
    else       r_prev <= i_in;
  end

  assign o_rise_c = i_in & ~r_prev;

endmodule

// File: rtl/cajero_param.sv
// Parametrised ATM transaction controller: card/PIN session, deposit and
// withdrawal on a registered balance, attempt lockout and idle timeout.
//   CLK, RESET            : clock, synchronous active-high reset
//   TARJETA_RECIBIDA      : card level (rising edge starts a session)
//   PIN_CORRECTO          : stored PIN, first digit in the top nibble
//   DIGITO, DIGITO_STB    : keypad digit and its level strobe
//   TIPO_TRANS, MONTO,
//   MONTO_STB             : transaction type/amount and their level strobe
//   BALANCE_INICIAL       : balance loaded while RESET is high
//   BALANCE_ACTUALIZADO,
//   ENTREGAR_DINERO,
//   PIN_INCORRECTO,
//   FONDOS_INSUFICIENTES,
//   ERROR_MONTO, TIMEOUT  : one-cycle result pulses
//   ADVERTENCIA, BLOQUEO  : last-attempt warning and lockout levels
//   BALANCE               : current balance
module cajero_param
  import cajero_pkg::*;
#(
  parameter int unsigned PIN_DIGITS   = 4,
  parameter int unsigned MAX_INTENTOS = 3,
  parameter int unsigned BAL_W        = 64,
  parameter int unsigned MONTO_W      = 32,
  parameter int unsigned TIMEOUT_CYC  = 64
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    TARJETA_RECIBIDA,
  input  logic [4*PIN_DIGITS-1:0] PIN_CORRECTO,
  input  logic [3:0]              DIGITO,
  input  logic                    DIGITO_STB,
  input  logic                    TIPO_TRANS,
  input  logic [MONTO_W-1:0]      MONTO,
  input  logic                    MONTO_STB,
  input  logic [BAL_W-1:0]        BALANCE_INICIAL,
  output logic                    BALANCE_ACTUALIZADO,
  output logic                    ENTREGAR_DINERO,
  output logic                    PIN_INCORRECTO,
  output logic                    ADVERTENCIA,
  output logic                    BLOQUEO,
  output logic                    FONDOS_INSUFICIENTES,
  output logic                    ERROR_MONTO,
  output logic                    TIMEOUT,
  output logic [BAL_W-1:0]        BALANCE
);

  localparam int unsigned PIN_W  = 4 * PIN_DIGITS;
  localparam int unsigned DCNT_W = $clog2(PIN_DIGITS + 1);
  localparam int unsigned ATT_W  = $clog2(MAX_INTENTOS + 1);
  localparam int unsigned TO_W   = $clog2(TIMEOUT_CYC);

  // Strobe event detection
  logic w_card_ev;
  logic w_dig_ev;
  logic w_monto_ev;
  logic w_any_ev;

  stb_edge u_card_edge (
    .i_clk    (CLK),
    .i_rst    (RESET),
    .i_in     (TARJETA_RECIBIDA),
    .o_rise_c (w_card_ev)
  );

  stb_edge u_dig_edge (
    .i_clk    (CLK),
    .i_rst    (RESET),
    .i_in     (DIGITO_STB),
    .o_rise_c (w_dig_ev)
  );

  stb_edge u_monto_edge (
    .i_clk    (CLK),
    .i_rst    (RESET),
    .i_in     (MONTO_STB),
    .o_rise_c (w_monto_ev)
  );

  assign w_any_ev = w_card_ev | w_dig_ev | w_monto_ev;

  // Controller registers
  state_t               r_state;
  logic [PIN_W-1:0]     r_pin;
  logic [DCNT_W-1:0]    r_dig_cnt;
  logic [ATT_W-1:0]     r_att;
  logic [TO_W-1:0]      r_to_cnt;
  logic [MONTO_W-1:0]   r_monto;
  logic [BAL_W-1:0]     r_balance;
  logic                 r_bal_upd;
  logic                 r_entregar;
  logic                 r_pin_inc;
  logic                 r_advert;
  logic                 r_bloqueo;
  logic                 r_fondos;
  logic                 r_err_monto;
  logic                 r_timeout;

  // Deposit sum carries one extra bit so overflow is visible as the MSB
  logic [BAL_W:0]       w_sum;
  logic                 w_sin_fondos;

  assign w_sum        = {1'b0, r_balance} + (BAL_W + 1)'(r_monto);
  assign w_sin_fondos = BAL_W'(r_monto) > r_balance;

  // Main controller
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state     <= S_IDLE;
      r_pin       <= '0;
      r_dig_cnt   <= '0;
      r_att       <= '0;
      r_to_cnt    <= '0;
      r_monto     <= '0;
      r_balance   <= BALANCE_INICIAL;
      r_bal_upd   <= 1'b0;
      r_entregar  <= 1'b0;
      r_pin_inc   <= 1'b0;
      r_advert    <= 1'b0;
      r_bloqueo   <= 1'b0;
      r_fondos    <= 1'b0;
      r_err_monto <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_bal_upd   <= 1'b0;
      r_entregar  <= 1'b0;
      r_pin_inc   <= 1'b0;
      r_fondos    <= 1'b0;
      r_err_monto <= 1'b0;
      r_timeout   <= 1'b0;

      // Inactivity timer; any strobe event restarts it
      if (timed_state(r_state)) begin
        if (w_any_ev) begin
          r_to_cnt <= '0;
        end else if (r_to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
          r_to_cnt <= '0;
        end else begin
          r_to_cnt <= r_to_cnt + TO_W'(1);
        end
      end else begin
        r_to_cnt <= '0;
      end

      case (r_state)
        S_IDLE: begin
          if (w_card_ev) begin
            r_state   <= S_PIN_ENTRY;
            r_dig_cnt <= '0;
            r_pin     <= '0;
          end
        end

        S_PIN_ENTRY: begin
          if (w_dig_ev) begin
            r_pin <= (r_pin << 4) | PIN_W'(DIGITO);
            if (r_dig_cnt == DCNT_W'(PIN_DIGITS - 1)) begin
              r_dig_cnt <= '0;
              r_state   <= S_CHECK_PIN;
            end else begin
              r_dig_cnt <= r_dig_cnt + DCNT_W'(1);
            end
          end else if (!w_any_ev && r_to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
            r_timeout <= 1'b1;
            r_pin     <= '0;
            r_dig_cnt <= '0;
            r_state   <= S_IDLE;
          end
        end

        S_CHECK_PIN: begin
          if (r_pin == PIN_CORRECTO) begin
            r_att    <= '0;
            r_advert <= 1'b0;
            r_state  <= S_ESPERA_MONTO;
          end else begin
            r_pin_inc <= 1'b1;
            r_pin     <= '0;
            r_dig_cnt <= '0;
            if (r_att == ATT_W'(MAX_INTENTOS - 1)) begin
              r_att     <= ATT_W'(MAX_INTENTOS);
              r_advert  <= 1'b0;
              r_bloqueo <= 1'b1;
              r_state   <= S_BLOQUEO;
            end else begin
              r_att    <= r_att + ATT_W'(1);
              // Warning when this failure leaves exactly one attempt
              r_advert <= (r_att == ATT_W'(MAX_INTENTOS - 2));
              r_state  <= S_PIN_ENTRY;
            end
          end
        end

        S_ESPERA_MONTO: begin
          if (w_monto_ev) begin
            r_monto <= MONTO;
            r_state <= (TIPO_TRANS == TIPO_RETIRO) ? S_RETIRO : S_DEPOSITO;
          end else if (!w_any_ev && r_to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
            r_timeout <= 1'b1;
            r_pin     <= '0;
            r_dig_cnt <= '0;
            r_state   <= S_IDLE;
          end
        end

        S_DEPOSITO: begin
          if (w_sum[BAL_W]) begin
            r_err_monto <= 1'b1;
          end else begin
            r_balance <= w_sum[BAL_W-1:0];
            r_bal_upd <= 1'b1;
          end
          r_state <= S_IDLE;
        end

        S_RETIRO: begin
          if (w_sin_fondos) begin
            r_fondos <= 1'b1;
          end else begin
            r_balance  <= r_balance - BAL_W'(r_monto);
            r_bal_upd  <= 1'b1;
            r_entregar <= 1'b1;
          end
          r_state <= S_IDLE;
        end

        S_BLOQUEO: begin
          r_bloqueo <= 1'b1;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign BALANCE_ACTUALIZADO  = r_bal_upd;
  assign ENTREGAR_DINERO      = r_entregar;
  assign PIN_INCORRECTO       = r_pin_inc;
  assign ADVERTENCIA          = r_advert;
  assign BLOQUEO              = r_bloqueo;
  assign FONDOS_INSUFICIENTES = r_fondos;
  assign ERROR_MONTO          = r_err_monto;
  assign TIMEOUT              = r_timeout;
  assign BALANCE              = r_balance;

endmodule

// File: doc/cajero_param.md
Name: cajero_param

Overview:
Parametrised ATM (cajero) transaction controller. It is the next generation of the fixed 4-digit, 3-attempt controller driven by the existing tester.
- Generalised in PIN length, attempt limit, balance width and amount width.
- Adds an inactivity timeout, strobe edge detection (strobes may be held high for several cycles) and an overflow-protected deposit.
- Sits between the card/keypad front end and the dispenser/balance display.

Parameters:
PIN_DIGITS, 4, number of BCD digits in the PIN (1..8).
MAX_INTENTOS, 3, wrong-PIN attempts before lockout (>=2).
BAL_W, 64, balance width in bits.
MONTO_W, 32, amount width in bits (MONTO_W <= BAL_W).
TIMEOUT_CYC, 64, idle cycles in a session before it is aborted (>=2).

Ports:
CLK  in  1  clock, all logic on rising edge.
RESET  in  1  synchronous, active-high reset.
TARJETA_RECIBIDA  in  1  card inserted (level; only its rising edge is used).
PIN_CORRECTO  in  4*PIN_DIGITS  stored PIN; most significant nibble is the first digit.
DIGITO  in  4  keypad digit.
DIGITO_STB  in  1  digit valid (level; only its rising edge is used).
TIPO_TRANS  in  1  0 = deposit, 1 = withdrawal; sampled together with MONTO.
MONTO  in  MONTO_W  transaction amount.
MONTO_STB  in  1  amount valid (level; only its rising edge is used).
BALANCE_INICIAL  in  BAL_W  balance loaded into the balance register during RESET.
BALANCE_ACTUALIZADO  out  1  one-cycle pulse: balance register updated.
ENTREGAR_DINERO  out  1  one-cycle pulse: dispense the withdrawn amount.
PIN_INCORRECTO  out  1  one-cycle pulse per wrong PIN.
ADVERTENCIA  out  1  level: one attempt remaining.
BLOQUEO  out  1  level: locked out.
FONDOS_INSUFICIENTES  out  1  one-cycle pulse: withdrawal rejected.
ERROR_MONTO  out  1  one-cycle pulse: deposit rejected due to overflow.
TIMEOUT  out  1  one-cycle pulse: session aborted for inactivity.
BALANCE  out  BAL_W  current balance (registered).

Behaviour:
Reset (RESET high at a clock edge):
- State goes to IDLE.
- BALANCE <= BALANCE_INICIAL.
- Attempt counter, digit counter, PIN shift register and timeout counter all cleared.
- Every pulse and level output is 0.
- RESET overrides everything, including mid-session and BLOQUEO; RESET is the only exit from BLOQUEO.

Strobe edge detection:
- DIGITO_STB, MONTO_STB and TARJETA_RECIBIDA each have a one-flop edge detector.
- An event is the cycle in which the input is 1 and its registered copy is 0.
- DIGITO is captured on the DIGITO_STB event cycle; MONTO and TIPO_TRANS are captured on the MONTO_STB event cycle.

State machine:
- IDLE: a TARJETA_RECIBIDA event moves to PIN_ENTRY and clears the digit count and timeout counter. All other events are ignored.
- PIN_ENTRY: each DIGITO_STB event shifts DIGITO into the PIN register and increments the digit count. When the count reaches PIN_DIGITS, go to CHECK_PIN.
- CHECK_PIN (exactly 1 cycle):
  - If the PIN register equals PIN_CORRECTO: clear the attempt counter and go to ESPERA_MONTO.
  - Otherwise: increment the attempt counter and pulse PIN_INCORRECTO.
    - If the counter now equals MAX_INTENTOS, go to BLOQUEO.
    - Otherwise, go to PIN_ENTRY with the digit count cleared.
- ESPERA_MONTO: a MONTO_STB event captures the amount and goes to DEPOSITO or RETIRO according to TIPO_TRANS.
- DEPOSITO (1 cycle): sum = BALANCE + zero-extended MONTO, computed at BAL_W+1 bits.
  - If the carry bit is set: BALANCE is unchanged and ERROR_MONTO pulses.
  - Otherwise: BALANCE <= sum and BALANCE_ACTUALIZADO pulses.
  - Go to IDLE in both cases.
- RETIRO (1 cycle):
  - If MONTO > BALANCE: FONDOS_INSUFICIENTES pulses.
  - Otherwise: BALANCE <= BALANCE - MONTO, and BALANCE_ACTUALIZADO and ENTREGAR_DINERO pulse together.
  - Go to IDLE in both cases. MONTO == BALANCE is allowed and leaves BALANCE = 0.
- BLOQUEO: BLOQUEO = 1; all inputs are ignored.

Level outputs:
- ADVERTENCIA = 1 when attempts == MAX_INTENTOS-1 and not locked.
- ADVERTENCIA and BLOQUEO are driven from registers.

Timeout:
- Applies in PIN_ENTRY and ESPERA_MONTO only.
- The counter clears on any strobe event.
- When it reaches TIMEOUT_CYC-1: TIMEOUT pulses and the state returns to IDLE. The attempt counter is kept; the PIN register and digit count are cleared.

Event corner cases:
- A TARJETA_RECIBIDA event outside IDLE is ignored.
- A DIGITO_STB event outside PIN_ENTRY is ignored.

Latency:
- Last PIN digit event to PIN_INCORRECTO pulse: 2 cycles.
- MONTO_STB event to BALANCE_ACTUALIZADO pulse: 2 cycles.

Decomposition:
- Package cajero_pkg holds:
  - the state enum (IDLE, PIN_ENTRY, CHECK_PIN, ESPERA_MONTO, DEPOSITO, RETIRO, BLOQUEO);
  - the TIPO_DEPOSITO = 0 and TIPO_RETIRO = 1 constants.
- One sub-module, stb_edge: a registered rising-edge detector with synchronous, active-high reset, instantiated three times.

Test Plan:
- BALANCE_INICIAL=0, PIN_CORRECTO=16'h3566; card, digits 3,5,6,6, TIPO_TRANS=0, MONTO=10000 -> BALANCE_ACTUALIZADO pulse, BALANCE=10000, no PIN_INCORRECTO.
- Continue: card, PIN 3566, TIPO_TRANS=1, MONTO=7000 -> ENTREGAR_DINERO and BALANCE_ACTUALIZADO pulse in the same cycle, BALANCE=3000.
- Card, then PINs 3561, 1111, 1534 -> PIN_INCORRECTO pulses three times; ADVERTENCIA=1 after the second; BLOQUEO=1 after the third. A further card and PIN 3566 gives no response. RESET clears BLOQUEO, and BALANCE reloads from BALANCE_INICIAL.
- BALANCE=3000 (BALANCE_INICIAL=3000), PIN 3566, withdrawal MONTO=900000 -> FONDOS_INSUFICIENTES pulse, BALANCE=3000, no ENTREGAR_DINERO. Repeat with MONTO=3000 -> BALANCE=0.
- Card, two digits, then idle TIMEOUT_CYC cycles -> TIMEOUT pulse, state IDLE, attempt count unchanged. A full 3566 entry afterwards is accepted.
- BAL_W=16, MONTO_W=16, BALANCE_INICIAL=16'hFFF0, deposit MONTO=16'h0020 -> ERROR_MONTO pulse, BALANCE=16'hFFF0. DIGITO_STB held high for 10 cycles counts as one digit.
